// File: rtl/blink_pkg.sv
// Shared definitions for the blink LCD fetch sequencer: attribute bit positions,
// character-set boundaries, fetch state encoding and the screen-file address helper.
package blink_pkg;

  localparam int ATTR_HRS   = 5;
  localparam int ATTR_CODE8 = 0;
  localparam int ATTR_CODE9 = 1;

  localparam logic [8:0] LORES0_FIRST = 9'h1C0;
  localparam logic [9:0] HIRES1_FIRST = 10'h300;

  typedef enum logic [2:0] {
    IDLE,
    ATTR_LO,
    ATTR_HI,
    FONT,
    OUT
  } fetch_state_e;

  // Each text row owns 256 bytes of the screen file: 128 columns of 2 bytes.
  function automatic logic [21:0] attr_addr(input logic [10:0] sbr,
                                            input logic [2:0]  row,
                                            input logic [6:0]  col,
                                            input logic        odd);
    return {sbr, row, col, odd};
  endfunction

endpackage

// File: rtl/blink_lcd_fetch_if.sv
// Valid/ready byte stream from the fetch sequencer to the LCD shifter.
interface blink_lcd_fetch_if;

  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       pix_hrs;
  logic       pix_eol;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_hrs,
    output pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_hrs,
    input  pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/blink_font_addr.sv
// Maps a character attribute and scan line to the font byte address in one of
// the four character sets. Purely combinational.
module blink_font_addr
  import blink_pkg::*;
(
  input  logic [7:0]  i_lo,
  input  logic [1:0]  i_code_hi,
  input  logic        i_hrs,
  input  logic [2:0]  i_s,
  input  logic [12:0] i_pb0,
  input  logic [9:0]  i_pb1,
  input  logic [8:0]  i_pb2,
  input  logic [10:0] i_pb3,
  output logic [21:0] o_addr
);

  logic [8:0] w_c9;
  logic [9:0] w_c10;

  assign w_c9  = {i_code_hi[0], i_lo};
  assign w_c10 = {i_code_hi, i_lo};

  always_comb begin
    // NOTE: o_addr gets a value before any branch so no path can infer a latch.
    o_addr = '0;
    if (i_hrs) begin
      if (w_c10 < HIRES1_FIRST) o_addr = {i_pb2, w_c10, i_s};
      else                      o_addr = {i_pb3, w_c10[7:0], i_s};
    end else begin
      if (w_c9 < LORES0_FIRST)  o_addr = {i_pb1, w_c9, i_s};
      else                      o_addr = {i_pb0, w_c9[5:0], i_s};
    end
  end

endmodule

// File: rtl/blink_lcd_fetch.sv
// Screen-refresh fetch sequencer: steals idle Z80 bus cycles to read each
// character attribute and font byte, then hands the byte to the LCD shifter.
module blink_lcd_fetch
  import blink_pkg::*;
#(
  parameter int COLS  = 106,
  parameter int LINES = 64
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        en,
  input  logic        mrq_n,
  input  logic [21:0] z80_ma,
  input  logic [10:0] sbr,
  input  logic [12:0] pb0,
  input  logic [9:0]  pb1,
  input  logic [8:0]  pb2,
  input  logic [10:0] pb3,
  input  logic [7:0]  mem_rdata,
  output logic [21:0] ma,
  output logic        lcd_own,
  output logic        frame_done,
  blink_lcd_fetch_if.master pix
);

  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0] LAST_LINE = 6'(LINES - 1);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [5:0]  r_line;
  logic [6:0]  r_col;
  logic [7:0]  r_lo;
  logic [1:0]  r_code_hi;
  logic        r_hrs;
  logic        r_pix_valid;
  logic [7:0]  r_pix_data;
  logic        r_pix_hrs;
  logic        r_pix_eol;
  logic        r_frame_done;

  logic        w_fetching;
  logic        w_grant;
  logic        w_accept;
  logic        w_last_col;
  logic        w_last_line;
  logic [21:0] w_attr_addr;
  logic [21:0] w_font_addr;
  logic [21:0] w_fetch_addr;

  // The Z80 always wins: a fetch state only gets the bus when MREQ is idle.
  assign w_fetching  = (r_state == ATTR_LO) || (r_state == ATTR_HI) || (r_state == FONT);
  assign w_grant     = w_fetching && mrq_n;
  assign w_accept    = (r_state == OUT) && r_pix_valid && pix.pix_ready;
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_line = (r_line == LAST_LINE);

  assign w_attr_addr  = attr_addr(sbr, r_line[5:3], r_col, r_state == ATTR_HI);
  assign w_fetch_addr = (r_state == FONT) ? w_font_addr : w_attr_addr;

  assign ma      = w_grant ? w_fetch_addr : z80_ma;
  assign lcd_own = w_grant;

  blink_font_addr u_font_addr (
    .i_lo      (r_lo),
    .i_code_hi (r_code_hi),
    .i_hrs     (r_hrs),
    .i_s       (r_line[2:0]),
    .i_pb0     (pb0),
    .i_pb1     (pb1),
    .i_pb2     (pb2),
    .i_pb3     (pb3),
    .o_addr    (w_font_addr)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (en)       w_next = ATTR_LO;
      ATTR_LO: if (w_grant)  w_next = ATTR_HI;
      ATTR_HI: if (w_grant)  w_next = FONT;
      FONT:    if (w_grant)  w_next = OUT;
      OUT:     if (w_accept) w_next = en ? ATTR_LO : IDLE;
      default:               w_next = IDLE;
    endcase
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      r_state      <= IDLE;
      r_line       <= '0;
      r_col        <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_hrs    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_state      <= w_next;
      r_frame_done <= 1'b0;

      if (w_grant && (r_state == FONT)) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= mem_rdata;
        r_pix_hrs   <= r_hrs;
        r_pix_eol   <= w_last_col;
      end

      if (w_accept) begin
        r_pix_valid <= 1'b0;
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_line) begin
            r_line       <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_line <= r_line + 6'd1;
          end
        end else begin
          r_col <= r_col + 7'd1;
        end
      end
    end
  end

  // NOTE: attribute holding registers need no reset; FONT is only reached after both are written.
  always_ff @(posedge mck) begin
    if (w_grant && (r_state == ATTR_LO)) begin
      r_lo <= mem_rdata;
    end
    if (w_grant && (r_state == ATTR_HI)) begin
      r_code_hi <= mem_rdata[ATTR_CODE9:ATTR_CODE8];
      r_hrs     <= mem_rdata[ATTR_HRS];
    end
  end

  assign pix.pix_valid = r_pix_valid;
  assign pix.pix_data  = r_pix_data;
  assign pix.pix_hrs   = r_pix_hrs;
  assign pix.pix_eol   = r_pix_eol;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_blink_lcd_fetch.sv
// Directed bench for blink_lcd_fetch: font-address vector table, bus stealing,
// shifter back-pressure, enable drop, reset mid-fetch and a full frame walk.
`timescale 1ns/1ps
module tb_blink_lcd_fetch;

  localparam int COLS  = 106;
  localparam int LINES = 64;

  logic        mck = 1'b0;
  logic        rin;
  logic        en;
  logic        mrq_n;
  logic [21:0] z80_ma;
  logic [10:0] sbr;
  logic [12:0] pb0;
  logic [9:0]  pb1;
  logic [8:0]  pb2;
  logic [10:0] pb3;
  logic [7:0]  mem_rdata;
  logic [21:0] ma;
  logic        lcd_own;
  logic        frame_done;

  logic [7:0]  fa_lo;
  logic [1:0]  fa_code_hi;
  logic        fa_hrs;
  logic [2:0]  fa_s;
  logic [12:0] fa_pb0;
  logic [9:0]  fa_pb1;
  logic [8:0]  fa_pb2;
  logic [10:0] fa_pb3;
  logic [21:0] fa_addr;

  logic [21:0] ovr_a0, ovr_a1;
  logic [7:0]  ovr_d0, ovr_d1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 mck = ~mck;

  blink_lcd_fetch_if pif ();

  blink_lcd_fetch #(.COLS(COLS), .LINES(LINES)) dut (
    .mck        (mck),
    .rin        (rin),
    .en         (en),
    .mrq_n      (mrq_n),
    .z80_ma     (z80_ma),
    .sbr        (sbr),
    .pb0        (pb0),
    .pb1        (pb1),
    .pb2        (pb2),
    .pb3        (pb3),
    .mem_rdata  (mem_rdata),
    .ma         (ma),
    .lcd_own    (lcd_own),
    .frame_done (frame_done),
    .pix        (pif)
  );

  blink_font_addr u_fa (
    .i_lo      (fa_lo),
    .i_code_hi (fa_code_hi),
    .i_hrs     (fa_hrs),
    .i_s       (fa_s),
    .i_pb0     (fa_pb0),
    .i_pb1     (fa_pb1),
    .i_pb2     (fa_pb2),
    .i_pb3     (fa_pb3),
    .o_addr    (fa_addr)
  );

  function automatic logic [7:0] mem_hash(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_at(input logic [21:0] a);
    if (a == ovr_a0) return ovr_d0;
    if (a == ovr_a1) return ovr_d1;
    return mem_hash(a);
  endfunction

  // Memory answers combinationally to whatever address is on the bus.
  always_comb begin
    mem_rdata = mem_hash(ma);
    if (ma == ovr_a0)      mem_rdata = ovr_d0;
    else if (ma == ovr_a1) mem_rdata = ovr_d1;
  end

  // Reference font address built arithmetically from the character-set rules.
  function automatic logic [21:0] model_font(input logic [7:0] lo, input logic [7:0] hi, input int s);
    int c;
    if (hi[5]) begin
      c = int'(hi[1:0]) * 256 + int'(lo);
      if (c < 768) return 22'(int'(pb2) * 8192 + c * 8 + s);
      return 22'(int'(pb3) * 2048 + (c % 256) * 8 + s);
    end
    c = int'(hi[0]) * 256 + int'(lo);
    if (c < 448) return 22'(int'(pb1) * 4096 + c * 8 + s);
    return 22'(int'(pb0) * 512 + (c % 64) * 8 + s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rin = 1'b1;
    repeat (2) @(negedge mck);
    rin = 1'b0;
  endtask

  // Wait (bounded) for the next granted fetch, check its address, step one cycle.
  task automatic wait_fetch(input string name, input logic [21:0] exp_addr);
    int n = 0;
    while (!lcd_own && n < 50) begin
      @(negedge mck);
      n++;
    end
    check({name, "_own"}, 32'(lcd_own), 32'd1);
    check(name, 32'(ma), 32'(exp_addr));
    @(negedge mck);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [2:0]  s;
    logic [12:0] pb0;
    logic [9:0]  pb1;
    logic [8:0]  pb2;
    logic [10:0] pb3;
    logic [21:0] addr;
  } fa_vec_t;

  fa_vec_t fa_tab [9];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] fa_exp;
    logic [7:0]  data_exp;

    rin = 1'b1; en = 1'b0; mrq_n = 1'b1; z80_ma = 22'h155AA5;
    sbr = 11'h001; pb0 = 13'h0003; pb1 = 10'h001; pb2 = 9'h005; pb3 = 11'h002;
    pif.pix_ready = 1'b0;
    ovr_a0 = 22'h000800; ovr_d0 = 8'h41;
    ovr_a1 = 22'h000801; ovr_d1 = 8'h00;

    // Font address unit: directed vectors covering every set and both boundaries.
    fa_tab[0] = '{8'h41, 8'h00, 3'd0, 13'h1ABC, 10'h001, 9'h0F0, 11'h555, 22'h001208};
    fa_tab[1] = '{8'hC5, 8'h01, 3'd2, 13'h0003, 10'h2AA, 9'h0F0, 11'h555, 22'h00062A};
    fa_tab[2] = '{8'h10, 8'h23, 3'd0, 13'h1ABC, 10'h2AA, 9'h0F0, 11'h002, 22'h001080};
    fa_tab[3] = '{8'hBF, 8'h01, 3'd7, 13'h1ABC, 10'h3FF, 9'h0F0, 11'h555, 22'h3FFDFF};
    fa_tab[4] = '{8'hC0, 8'h01, 3'd0, 13'h1FFF, 10'h2AA, 9'h0F0, 11'h555, 22'h3FFE00};
    fa_tab[5] = '{8'hFF, 8'h22, 3'd1, 13'h1ABC, 10'h2AA, 9'h001, 11'h555, 22'h0037F9};
    fa_tab[6] = '{8'h00, 8'h23, 3'd5, 13'h1ABC, 10'h2AA, 9'h0F0, 11'h7FF, 22'h3FF805};
    fa_tab[7] = '{8'hFF, 8'hDE, 3'd3, 13'h1ABC, 10'h155, 9'h0F0, 11'h555, 22'h1557FB};
    fa_tab[8] = '{8'hFF, 8'h23, 3'd6, 13'h1ABC, 10'h2AA, 9'h0F0, 11'h001, 22'h000FFE};
    for (int i = 0; i < 9; i++) begin
      fa_lo      = fa_tab[i].lo;
      fa_code_hi = fa_tab[i].hi[1:0];
      fa_hrs     = fa_tab[i].hi[5];
      fa_s       = fa_tab[i].s;
      fa_pb0     = fa_tab[i].pb0;
      fa_pb1     = fa_tab[i].pb1;
      fa_pb2     = fa_tab[i].pb2;
      fa_pb3     = fa_tab[i].pb3;
      #1;
      check($sformatf("fa_vec%0d", i), 32'(fa_addr), 32'(fa_tab[i].addr));
    end

    // A: reset state, lores character at line 0 col 0, then shifter back-pressure.
    repeat (2) @(negedge mck);
    check("rst_ma",         32'(ma),            32'(z80_ma));
    check("rst_lcd_own",    32'(lcd_own),       32'd0);
    check("rst_pix_valid",  32'(pif.pix_valid), 32'd0);
    check("rst_pix_data",   32'(pif.pix_data),  32'd0);
    check("rst_pix_hrs",    32'(pif.pix_hrs),   32'd0);
    check("rst_pix_eol",    32'(pif.pix_eol),   32'd0);
    check("rst_frame_done", 32'(frame_done),    32'd0);
    rin = 1'b0;
    en  = 1'b1;
    @(negedge mck);
    wait_fetch("a_attr_lo", 22'h000800);
    wait_fetch("a_attr_hi", 22'h000801);
    wait_fetch("a_font",    22'h001208);
    data_exp = mem_hash(22'h001208);
    check("a_pix_valid", 32'(pif.pix_valid), 32'd1);
    check("a_pix_data",  32'(pif.pix_data),  32'(data_exp));
    check("a_pix_hrs",   32'(pif.pix_hrs),   32'd0);
    check("a_pix_eol",   32'(pif.pix_eol),   32'd0);
    for (int i = 0; i < 10; i++) begin
      check("a_backpressure", 32'({pif.pix_valid, lcd_own, pif.pix_data}), 32'({1'b1, 1'b0, data_exp}));
      @(negedge mck);
    end
    pif.pix_ready = 1'b1;
    @(negedge mck);
    check("a_accept_clears_valid", 32'(pif.pix_valid), 32'd0);
    wait_fetch("a_next_col", 22'h000802);

    // B: hires character with the Z80 holding the bus for 5 cycles in ATTR_HI.
    ovr_d0 = 8'h10;
    ovr_d1 = 8'h23;
    do_reset();
    @(negedge mck);
    wait_fetch("b_attr_lo", 22'h000800);
    for (int i = 0; i < 5; i++) begin
      mrq_n  = 1'b0;
      z80_ma = 22'h200000 + 22'(i * 22'h111);
      #1;
      check("b_z80_stall", 32'({lcd_own, ma}), 32'({1'b0, z80_ma}));
      @(negedge mck);
    end
    mrq_n = 1'b1;
    #1;
    wait_fetch("b_attr_hi", 22'h000801);
    wait_fetch("b_font",    22'h001080);
    check("b_pix_hrs",  32'(pif.pix_hrs),  32'd1);
    check("b_pix_data", 32'(pif.pix_data), 32'(mem_hash(22'h001080)));

    // E: enable dropped mid-character finishes the character, idles, resumes at col 1.
    ovr_d0 = 8'h41;
    ovr_d1 = 8'h00;
    do_reset();
    @(negedge mck);
    wait_fetch("e_attr_lo", 22'h000800);
    en = 1'b0;
    wait_fetch("e_attr_hi", 22'h000801);
    wait_fetch("e_font",    22'h001208);
    check("e_pix_valid", 32'(pif.pix_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge mck);
      check("e_idle", 32'({lcd_own, pif.pix_valid}), 32'd0);
    end
    en = 1'b1;
    @(negedge mck);
    wait_fetch("e_resume", 22'h000802);

    // C: reset asserted while in FONT after a few characters.
    do_reset();
    @(negedge mck);
    for (int k = 0; k < 3; k++) begin
      wait_fetch("c_attr_lo", 22'h000800 + 22'(2 * k));
      wait_fetch("c_attr_hi", 22'h000801 + 22'(2 * k));
      fa_exp = model_font(mem_at(22'h000800 + 22'(2 * k)), mem_at(22'h000801 + 22'(2 * k)), 0);
      wait_fetch("c_font", fa_exp);
    end
    wait_fetch("c_attr_lo", 22'h000806);
    wait_fetch("c_attr_hi", 22'h000807);
    rin = 1'b1;
    @(negedge mck);
    check("c_rst_pix_valid", 32'(pif.pix_valid), 32'd0);
    check("c_rst_lcd_own",   32'(lcd_own),       32'd0);
    check("c_rst_pix_data",  32'(pif.pix_data),  32'd0);
    rin = 1'b0;
    @(negedge mck);
    wait_fetch("c_restart", 22'h000800);

    // D: full frame with random Z80 activity, every byte checked against the model.
    ovr_a0 = 22'h3FFFFF;
    ovr_a1 = 22'h3FFFFF;
    do_reset();
    begin
      int bytes = 0, dones = 0, data_err = 0, eol_err = 0, cyc = 0;
      int m_line = 0, m_col = 0;
      logic [21:0] a;
      logic [7:0]  lo, hi;
      while (dones == 0 && cyc < 60000) begin
        @(negedge mck);
        cyc++;
        if (frame_done) dones++;
        if (pif.pix_valid && pif.pix_ready) begin
          a  = 22'(int'(sbr) * 2048 + (m_line / 8) * 256 + m_col * 2);
          lo = mem_at(a);
          hi = mem_at(a + 22'd1);
          data_exp = mem_at(model_font(lo, hi, m_line % 8));
          if (pif.pix_data !== data_exp || pif.pix_hrs !== hi[5]) data_err++;
          if (pif.pix_eol !== (m_col == COLS - 1)) eol_err++;
          bytes++;
          if (m_col == COLS - 1) begin
            m_col  = 0;
            m_line = (m_line == LINES - 1) ? 0 : m_line + 1;
          end else begin
            m_col++;
          end
        end
        mrq_n  = ($urandom_range(0, 7) != 0);
        z80_ma = 22'($urandom);
      end
      check("d_frame_done_seen", 32'(dones),    32'd1);
      check("d_byte_count",      32'(bytes),    32'(COLS * LINES));
      check("d_data_errors",     32'(data_err), 32'd0);
      check("d_eol_errors",      32'(eol_err),  32'd0);
      mrq_n = 1'b1;
      #1;
      check("d_wrap_own",  32'(lcd_own), 32'd1);
      check("d_wrap_addr", 32'(ma),      32'h000800);
      @(negedge mck);
      check("d_frame_done_pulse", 32'(frame_done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
